// File: rtl/fetch_sequencer.sv
// Instruction fetch / program sequencer: fetches 16-bit words, pulses the opcode to
// the control decoder for one cycle, then resolves branch outcome and advances pc.
module fetch_sequencer #(
  parameter int PC_W  = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic [15:0]      imem_rdata,
  input  logic             imem_valid,
  output logic [3:0]       opcd,
  output logic [3:0]       rd,
  output logic [3:0]       ra,
  output logic [3:0]       rb,
  output logic [7:0]       imm,
  input  logic [1:0]       branch,
  input  logic             zero,
  input  logic             neg,
  output logic [PC_W-1:0]  pc,
  output logic             illegal,
  output logic [CNT_W-1:0] retire_cnt
);

  typedef enum logic [1:0] {IDLE, FETCH, ISSUE, RESOLVE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [PC_W-1:0]  r_pc;
  logic [15:0]      r_ir;
  logic [3:0]       r_opcd;
  logic             r_req;
  logic             r_illegal;
  logic [CNT_W-1:0] r_cnt;

  logic             w_taken;
  logic             w_legal;
  logic [PC_W-1:0]  w_offset;
  logic [PC_W-1:0]  w_pc_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (en) w_next = FETCH;
      FETCH: begin
        if (imem_valid)  w_next = ISSUE;
        else if (!en)    w_next = IDLE;
      end
      ISSUE:   w_next = RESOLVE;
      RESOLVE: w_next = en ? FETCH : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Unknown or reserved branch codes fall through as not taken.
  always_comb begin
    w_taken = 1'b0;
    if (branch == 2'b01 && zero) w_taken = 1'b1;
    if (branch == 2'b10 && neg)  w_taken = 1'b1;
  end

  always_comb begin
    w_legal = 1'b0;
    case (r_opcd)
      4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h7, 4'hC, 4'hD: w_legal = 1'b1;
      default: w_legal = 1'b0;
    endcase
  end

  // Branch offset is relative to the branch instruction's own pc.
  assign w_offset  = PC_W'(signed'(r_ir[7:0]));
  assign w_pc_next = w_taken ? (r_pc + w_offset) : (r_pc + PC_W'(1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_pc      <= '0;
      r_ir      <= '0;
      r_opcd    <= 4'h0;
      r_req     <= 1'b0;
      r_illegal <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_state <= w_next;
      r_req   <= (w_next == FETCH);
      case (r_state)
        FETCH: begin
          if (imem_valid) begin
            r_ir   <= imem_rdata;
            r_opcd <= imem_rdata[15:12];
          end
        end
        ISSUE: begin
          r_opcd    <= 4'h0;
          r_illegal <= !w_legal;
        end
        RESOLVE: begin
          r_pc      <= w_pc_next;
          r_illegal <= 1'b0;
          if (r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign imem_req   = r_req;
  assign imem_addr  = r_pc;
  assign pc         = r_pc;
  assign opcd       = r_opcd;
  assign illegal    = r_illegal;
  assign retire_cnt = r_cnt;
  assign rd         = r_ir[11:8];
  assign ra         = r_ir[7:4];
  assign rb         = r_ir[3:0];
  assign imm        = r_ir[7:0];

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: each scenario task drives the imem/decoder
// side at negedge and compares outputs against hand-computed values.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_valid;
  logic [3:0]  opcd, rd, ra, rb;
  logic [7:0]  imm;
  logic [1:0]  branch;
  logic        zero, neg;
  logic [7:0]  pc;
  logic        illegal;
  logic [15:0] retire_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_sequencer #(.PC_W(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .en(en),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .opcd(opcd), .rd(rd), .ra(ra), .rb(rb), .imm(imm),
    .branch(branch), .zero(zero), .neg(neg),
    .pc(pc), .illegal(illegal), .retire_cnt(retire_cnt)
  );

  // Starts in FETCH at a negedge; ends at the negedge after RESOLVE.
  task automatic run_instr(input logic [15:0] instr, input int lat,
                           input logic [1:0] br, input logic z, input logic n,
                           output logic [3:0] issueOpcd, output logic issueIll,
                           output logic [3:0] resolveOpcd, output logic resolveIll,
                           output int reqCycles);
    reqCycles = 0;
    for (int i = 0; i < lat; i++) begin
      imem_valid = 1'b0;
      if (imem_req) reqCycles++;
      @(negedge clk);
    end
    if (imem_req) reqCycles++;
    imem_valid = 1'b1;
    imem_rdata = instr;
    @(negedge clk);
    imem_valid  = 1'b0;
    imem_rdata  = 16'hFFFF;
    issueOpcd   = opcd;
    issueIll    = illegal;
    branch = br; zero = z; neg = n;
    @(negedge clk);
    resolveOpcd = opcd;
    resolveIll  = illegal;
    @(negedge clk);
    branch = 2'b00; zero = 1'b0; neg = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b0; imem_valid = 1'b0; imem_rdata = 16'h0;
    branch = 2'b00; zero = 1'b0; neg = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req got %b exp 0", imem_req); end
    checks++; if (pc !== 8'h00) begin errors++; $display("[TB] FAIL reset_pc got %h exp 00", pc); end
    checks++; if (opcd !== 4'h0) begin errors++; $display("[TB] FAIL reset_opcd got %h exp 0", opcd); end
    checks++; if (illegal !== 1'b0) begin errors++; $display("[TB] FAIL reset_illegal got %b exp 0", illegal); end
    checks++; if (retire_cnt !== 16'h0) begin errors++; $display("[TB] FAIL reset_cnt got %h exp 0", retire_cnt); end
    checks++; if ({rd, ra, rb, imm} !== 20'h0) begin errors++; $display("[TB] FAIL reset_fields got %h exp 0", {rd, ra, rb, imm}); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL idle_no_req got %b exp 0", imem_req); end
  endtask

  task automatic test_sequential();
    logic [15:0] prog [3] = '{16'h1123, 16'h2456, 16'h3789};
    logic [3:0] io, ro; logic ii, ri; int rq;
    en = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++; if (imem_req !== 1'b1 || imem_addr !== 8'(k)) begin errors++; $display("[TB] FAIL seq_fetch%0d got req %b addr %h exp 1 %h", k, imem_req, imem_addr, 8'(k)); end
      run_instr(prog[k], 0, 2'b00, 1'b0, 1'b0, io, ii, ro, ri, rq);
      checks++; if (io !== 4'(k + 1)) begin errors++; $display("[TB] FAIL seq_opcd%0d got %h exp %h", k, io, 4'(k + 1)); end
      checks++; if (ro !== 4'h0) begin errors++; $display("[TB] FAIL seq_opcd_clear%0d got %h exp 0", k, ro); end
      checks++; if (pc !== 8'(k + 1)) begin errors++; $display("[TB] FAIL seq_pc%0d got %h exp %h", k, pc, 8'(k + 1)); end
      if (k == 0) begin
        checks++; if ({rd, ra, rb, imm} !== 20'h12323) begin errors++; $display("[TB] FAIL seq_fields got %h exp 12323", {rd, ra, rb, imm}); end
      end
    end
    checks++; if (retire_cnt !== 16'd3) begin errors++; $display("[TB] FAIL seq_cnt got %0d exp 3", retire_cnt); end
  endtask

  task automatic test_beq();
    logic [3:0] io, ro; logic ii, ri; int rq;
    run_instr(16'hC00D, 0, 2'b01, 1'b1, 1'b0, io, ii, ro, ri, rq);
    checks++; if (pc !== 8'h10) begin errors++; $display("[TB] FAIL beq_fwd got %h exp 10", pc); end
    checks++; if (ri !== 1'b0 || io !== 4'hC) begin errors++; $display("[TB] FAIL beq_issue got ill %b opcd %h exp 0 c", ri, io); end
    run_instr(16'hC0FD, 0, 2'b01, 1'b1, 1'b0, io, ii, ro, ri, rq);
    checks++; if (pc !== 8'h0D) begin errors++; $display("[TB] FAIL beq_back got %h exp 0d", pc); end
    run_instr(16'hC003, 0, 2'b01, 1'b1, 1'b0, io, ii, ro, ri, rq);
    run_instr(16'hC0FD, 0, 2'b01, 1'b0, 1'b1, io, ii, ro, ri, rq);
    checks++; if (pc !== 8'h11) begin errors++; $display("[TB] FAIL beq_not_taken got %h exp 11", pc); end
    run_instr(16'hC0FD, 0, 2'b11, 1'b1, 1'b1, io, ii, ro, ri, rq);
    checks++; if (pc !== 8'h12) begin errors++; $display("[TB] FAIL br11_not_taken got %h exp 12", pc); end
  endtask

  task automatic test_blt();
    logic [3:0] io, ro; logic ii, ri; int rq;
    run_instr(16'hD00E, 0, 2'b10, 1'b0, 1'b1, io, ii, ro, ri, rq);
    checks++; if (pc !== 8'h20) begin errors++; $display("[TB] FAIL blt_setup got %h exp 20", pc); end
    run_instr(16'hD005, 0, 2'b10, 1'b0, 1'b1, io, ii, ro, ri, rq);
    checks++; if (pc !== 8'h25) begin errors++; $display("[TB] FAIL blt_taken got %h exp 25", pc); end
    run_instr(16'hD0FB, 0, 2'b10, 1'b0, 1'b1, io, ii, ro, ri, rq);
    run_instr(16'hD005, 0, 2'b10, 1'b1, 1'b0, io, ii, ro, ri, rq);
    checks++; if (pc !== 8'h21) begin errors++; $display("[TB] FAIL blt_not_taken got %h exp 21", pc); end
    checks++; if (retire_cnt !== 16'd12) begin errors++; $display("[TB] FAIL blt_cnt got %0d exp 12", retire_cnt); end
  endtask

  task automatic test_mem_wait();
    logic [3:0] io, ro; logic ii, ri; int rq;
    run_instr(16'h2456, 3, 2'b00, 1'b0, 1'b0, io, ii, ro, ri, rq);
    checks++; if (rq !== 4) begin errors++; $display("[TB] FAIL wait_req_cycles got %0d exp 4", rq); end
    checks++; if (io !== 4'h2 || pc !== 8'h22) begin errors++; $display("[TB] FAIL wait_result got opcd %h pc %h exp 2 22", io, pc); end
    imem_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (imem_req !== 1'b0 || pc !== 8'h00 || opcd !== 4'h0) begin errors++; $display("[TB] FAIL midreset got req %b pc %h opcd %h exp 0 00 0", imem_req, pc, opcd); end
    checks++; if (retire_cnt !== 16'h0) begin errors++; $display("[TB] FAIL midreset_cnt got %0d exp 0", retire_cnt); end
    rst = 1'b1; en = 1'b0;
    imem_valid = 1'b1; imem_rdata = 16'h1123;
    repeat (2) @(negedge clk);
    imem_valid = 1'b0;
    checks++; if (imem_req !== 1'b0 || opcd !== 4'h0 || rd !== 4'h0) begin errors++; $display("[TB] FAIL late_valid got req %b opcd %h rd %h exp 0 0 0", imem_req, opcd, rd); end
  endtask

  task automatic test_en_drop();
    logic [3:0] io, ro; logic ii, ri; int rq;
    en = 1'b1;
    @(negedge clk);
    checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL endrop_fetch got %b exp 1", imem_req); end
    en = 1'b0;
    @(negedge clk);
    checks++; if (imem_req !== 1'b0 || pc !== 8'h00) begin errors++; $display("[TB] FAIL endrop_idle got req %b pc %h exp 0 00", imem_req, pc); end
    en = 1'b1;
    @(negedge clk);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin errors++; $display("[TB] FAIL endrop_resume got req %b addr %h exp 1 00", imem_req, imem_addr); end
    run_instr(16'h2456, 0, 2'b00, 1'b0, 1'b0, io, ii, ro, ri, rq);
    checks++; if (io !== 4'h2 || pc !== 8'h01) begin errors++; $display("[TB] FAIL endrop_exec got opcd %h pc %h exp 2 01", io, pc); end
  endtask

  task automatic test_illegal_wrap();
    logic [3:0] io, ro; logic ii, ri; int rq;
    run_instr(16'hC0FE, 0, 2'b01, 1'b1, 1'b0, io, ii, ro, ri, rq);
    checks++; if (pc !== 8'hFF) begin errors++; $display("[TB] FAIL wrap_setup got %h exp ff", pc); end
    run_instr(16'h5000, 0, 2'b00, 1'b0, 1'b0, io, ii, ro, ri, rq);
    checks++; if (io !== 4'h5 || ii !== 1'b0) begin errors++; $display("[TB] FAIL ill_issue got opcd %h ill %b exp 5 0", io, ii); end
    checks++; if (ri !== 1'b1) begin errors++; $display("[TB] FAIL ill_resolve got %b exp 1", ri); end
    checks++; if (illegal !== 1'b0) begin errors++; $display("[TB] FAIL ill_clear got %b exp 0", illegal); end
    checks++; if (pc !== 8'h00) begin errors++; $display("[TB] FAIL pc_wrap got %h exp 00", pc); end
    checks++; if (retire_cnt !== 16'd3) begin errors++; $display("[TB] FAIL ill_cnt got %0d exp 3", retire_cnt); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_beq();
    test_blt();
    test_mem_wait();
    test_en_drop();
    test_illegal_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] timeout");
  end

endmodule
